// File: rtl/pupil_overlay_marker_if.sv
// Stream and centre-update signals of the pupil overlay marker, grouped so
// the marker and its environment share one bundle.
interface pupil_overlay_marker_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_pixel;
  logic       in_sof;
  logic       center_valid;
  logic [9:0] xcenter;
  logic [9:0] ycenter;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_pixel;
  logic       out_sof;
  logic       out_eol;
  logic       out_eof;
  logic       err_sof;

  // marker side
  modport slave (
    input  in_valid, in_pixel, in_sof, center_valid, xcenter, ycenter, out_ready,
    output in_ready, out_valid, out_pixel, out_sof, out_eol, out_eof, err_sof
  );

  // source / sink side
  modport master (
    output in_valid, in_pixel, in_sof, center_valid, xcenter, ycenter, out_ready,
    input  in_ready, out_valid, out_pixel, out_sof, out_eol, out_eof, err_sof
  );
endinterface

// File: rtl/pupil_overlay_marker.sv
// Draws a crosshair at the detected pupil centre on a raster pixel stream.
// A new centre is held pending and only takes effect on the next accepted
// start-of-frame pixel, so a frame never shows a split marker.
//
// state  | meaning
// IDLE   | waiting for a start-of-frame pixel; non-sof pixels are dropped
// ACTIVE | inside a frame; every accepted pixel is marked and forwarded
module pupil_overlay_marker #(
  parameter int         IMG_W     = 320,
  parameter int         IMG_H     = 240,
  parameter int         CROSS_LEN = 8,
  parameter logic [7:0] MARK_VAL  = 8'hFF
) (
  input logic                   clk,
  input logic                   rst,
  pupil_overlay_marker_if.slave bus
);

  localparam logic [9:0]  X_LAST  = 10'(IMG_W - 1);
  localparam logic [9:0]  Y_LAST  = 10'(IMG_H - 1);
  localparam logic [10:0] ARM_LEN = 11'(CROSS_LEN);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [9:0]  x;
  logic [9:0]  y;
  logic [9:0]  x_nxt;
  logic [9:0]  y_nxt;
  logic [9:0]  cur_x;
  logic [9:0]  cur_y;

  logic [9:0]  pend_x;
  logic [9:0]  pend_y;
  logic        pend_flag;
  logic [9:0]  act_x;
  logic [9:0]  act_y;
  logic        have_ctr;
  logic [9:0]  eff_x;
  logic [9:0]  eff_y;
  logic        eff_have;

  logic        accept;
  logic        take;
  logic        sof_take;
  logic        ctr_swap;
  logic        at_eol;
  logic        at_eof;
  logic        err_nxt;

  logic [10:0] dx;
  logic [10:0] dy;
  logic [10:0] dx_abs;
  logic [10:0] dy_abs;
  logic        mark;

  // Gated by reset so nothing is accepted while the block is held in reset.
  assign bus.in_ready = rst & (~bus.out_valid | bus.out_ready);
  assign accept       = bus.in_valid & bus.in_ready;
  assign take         = accept & ((state == ACTIVE) | bus.in_sof);
  assign sof_take     = accept & bus.in_sof;
  assign ctr_swap     = sof_take & pend_flag;

  // A sof pixel always restarts the raster, whatever the counters say.
  assign cur_x = bus.in_sof ? 10'd0 : x;
  assign cur_y = bus.in_sof ? 10'd0 : y;

  // The sof pixel that promotes a pending centre is already marked with it.
  assign eff_x    = (bus.in_sof & pend_flag) ? pend_x : act_x;
  assign eff_y    = (bus.in_sof & pend_flag) ? pend_y : act_y;
  assign eff_have = have_ctr | (bus.in_sof & pend_flag);

  assign at_eol  = (cur_x == X_LAST);
  assign at_eof  = at_eol & (cur_y == Y_LAST);
  assign err_nxt = sof_take & (state == ACTIVE) & ((x != 10'd0) | (y != 10'd0));

  // Distance to the centre; operands are below 1024 so bit 10 is the sign.
  always_comb begin
    dx     = {1'b0, cur_x} - {1'b0, eff_x};
    dy     = {1'b0, cur_y} - {1'b0, eff_y};
    dx_abs = dx[10] ? (~dx + 11'd1) : dx;
    dy_abs = dy[10] ? (~dy + 11'd1) : dy;
    mark   = eff_have & (((cur_y == eff_y) & (dx_abs <= ARM_LEN)) |
                         ((cur_x == eff_x) & (dy_abs <= ARM_LEN)));
  end

  // Raster position advance and frame state transitions.
  always_comb begin
    state_nxt = state;
    x_nxt     = x;
    y_nxt     = y;
    if (take) begin
      if (at_eof) begin
        x_nxt     = 10'd0;
        y_nxt     = 10'd0;
        state_nxt = IDLE;
      end else if (at_eol) begin
        x_nxt     = 10'd0;
        y_nxt     = cur_y + 10'd1;
        state_nxt = ACTIVE;
      end else begin
        x_nxt     = cur_x + 10'd1;
        y_nxt     = cur_y;
        state_nxt = ACTIVE;
      end
    end
  end

  // State and raster counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      x     <= 10'd0;
      y     <= 10'd0;
    end else begin
      state <= state_nxt;
      x     <= x_nxt;
      y     <= y_nxt;
    end
  end

  // Pending/active centre; a pulse coinciding with the swap waits for the next frame.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_x    <= 10'd0;
      pend_y    <= 10'd0;
      pend_flag <= 1'b0;
      act_x     <= 10'd0;
      act_y     <= 10'd0;
      have_ctr  <= 1'b0;
    end else begin
      if (ctr_swap) begin
        act_x    <= pend_x;
        act_y    <= pend_y;
        have_ctr <= 1'b1;
      end
      if (bus.center_valid) begin
        pend_x    <= bus.xcenter;
        pend_y    <= bus.ycenter;
        pend_flag <= 1'b1;
      end else if (ctr_swap) begin
        pend_flag <= 1'b0;
      end
    end
  end

  // Single output register; it holds while the sink stalls.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.out_valid <= 1'b0;
      bus.out_pixel <= 8'd0;
      bus.out_sof   <= 1'b0;
      bus.out_eol   <= 1'b0;
      bus.out_eof   <= 1'b0;
      bus.err_sof   <= 1'b0;
    end else begin
      bus.err_sof <= err_nxt;
      if (take) begin
        bus.out_valid <= 1'b1;
        bus.out_pixel <= mark ? MARK_VAL : bus.in_pixel;
        bus.out_sof   <= bus.in_sof;
        bus.out_eol   <= at_eol;
        bus.out_eof   <= at_eof;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pupil_overlay_marker.sv
// Directed bench for pupil_overlay_marker on a reduced 40x30 raster.
module tb_pupil_overlay_marker;
  localparam int W  = 40;
  localparam int H  = 30;
  localparam int N  = W * H;
  localparam int CL = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pupil_overlay_marker_if bus();

  pupil_overlay_marker #(
    .IMG_W(W), .IMG_H(H), .CROSS_LEN(CL), .MARK_VAL(8'hFF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int err_cnt  = 0;
  int viol     = 0;
  int cyc      = 0;

  logic [7:0] q_pix[$];
  bit         q_sof[$];
  bit         q_eol[$];
  bit         q_eof[$];
  logic [7:0] ref3[$];

  always @(posedge clk) cyc++;

  // capture every transferred output pixel, sampled mid-cycle
  always @(negedge clk) begin
    if (rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      q_pix.push_back(bus.out_pixel);
      q_sof.push_back(bus.out_sof);
      q_eol.push_back(bus.out_eol);
      q_eof.push_back(bus.out_eof);
    end
    if (bus.err_sof === 1'b1) err_cnt++;
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b0 && bus.in_ready !== 1'b0) viol++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    q_pix.delete();
    q_sof.delete();
    q_eol.delete();
    q_eof.delete();
  endtask

  task automatic send_pix(input logic [7:0] val, input bit sof, input bit rnd);
    bit acc = 0;
    bus.in_valid = 1'b1;
    bus.in_pixel = val;
    bus.in_sof   = sof;
    for (int t = 0; t < 64; t++) begin
      if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = (bus.in_ready === 1'b1);
      step();
      if (acc) break;
    end
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    if (!acc) begin
      n_checks++;
      $display("FAIL send_timeout: pixel not accepted within 64 cycles, required acceptance");
    end
  endtask

  task automatic send_frame(input logic [7:0] val, input int count, input bit first_sof, input bit rnd);
    for (int i = 0; i < count; i++) send_pix(val, first_sof && i == 0, rnd);
  endtask

  task automatic pulse_center(input int cx, input int cy);
    bus.center_valid = 1'b1;
    bus.xcenter      = 10'(cx);
    bus.ycenter      = 10'(cy);
    step();
    bus.center_valid = 1'b0;
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    repeat (4) step();
  endtask

  function automatic bit exp_mark(input int xx, input int yy, input int cx, input int cy);
    int dx;
    int dy;
    dx = (xx > cx) ? xx - cx : cx - xx;
    dy = (yy > cy) ? yy - cy : cy - yy;
    return (yy == cy && dx <= CL) || (xx == cx && dy <= CL);
  endfunction

  // Tallies captured outputs [start, start+len) against a frame starting at start.
  task automatic score(input int start, input int len, input int cx, input int cy,
                       input bit have, input logic [7:0] bg,
                       output int bad, output int flag_bad, output int marked);
    bad = 0; flag_bad = 0; marked = 0;
    for (int k = start; k < start + len; k++) begin
      int p, xx, yy;
      bit m;
      logic [7:0] e;
      p  = k - start;
      xx = p % W;
      yy = p / W;
      m  = have && exp_mark(xx, yy, cx, cy);
      e  = m ? 8'hFF : bg;
      if (m) marked++;
      if (k >= q_pix.size()) begin
        bad++;
        flag_bad++;
      end else begin
        if (q_pix[k] !== e) bad++;
        if (q_sof[k] !== (p == 0) || q_eol[k] !== (xx == W - 1) || q_eof[k] !== (p == N - 1))
          flag_bad++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_sof   = 1'b1;
    bus.in_pixel = 8'h55;
    bus.out_ready = 1'b1;
    repeat (3) step();
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
    else n_pass++;
    n_checks++;
    if (bus.err_sof !== 1'b0) $display("FAIL reset_err_sof: got %b want 0", bus.err_sof);
    else n_pass++;
    n_checks++;
    if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", bus.in_ready);
    else n_pass++;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    step();
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) $display("FAIL release_in_ready: got %b want 1", bus.in_ready);
    else n_pass++;
  endtask

  task automatic test_drop_before_sof();
    clear_q();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) send_pix(8'h77, 1'b0, 1'b0);
    drain();
    n_checks++;
    if (q_pix.size() !== 0 || bus.out_valid !== 1'b0)
      $display("FAIL drop_before_sof: got %0d outputs want 0", q_pix.size());
    else n_pass++;
  endtask

  task automatic test_plain_frame();
    int bad, fb, mk, t0, t1;
    clear_q();
    bus.out_ready = 1'b1;
    t0 = cyc;
    send_pix(8'h40, 1'b1, 1'b0);
    n_checks++;
    if ({bus.out_valid, bus.out_sof, bus.out_pixel} !== {1'b1, 1'b1, 8'h40})
      $display("FAIL latency_first: got v=%b sof=%b px=%h want v=1 sof=1 px=40",
               bus.out_valid, bus.out_sof, bus.out_pixel);
    else n_pass++;
    send_frame(8'h40, N - 1, 1'b0, 1'b0);
    t1 = cyc;
    drain();
    n_checks++;
    if (t1 - t0 !== N) $display("FAIL throughput: got %0d cycles want %0d", t1 - t0, N);
    else n_pass++;
    score(0, N, 0, 0, 1'b0, 8'h40, bad, fb, mk);
    n_checks++;
    if (q_pix.size() !== N) $display("FAIL plain_count: got %0d want %0d", q_pix.size(), N);
    else n_pass++;
    n_checks++;
    if (bad !== 0) $display("FAIL plain_pixels: got %0d wrong want 0", bad);
    else n_pass++;
    n_checks++;
    if (fb !== 0) $display("FAIL plain_flags: got %0d wrong want 0", fb);
    else n_pass++;
  endtask

  task automatic test_center();
    int bad, fb, mk;
    clear_q();
    pulse_center(20, 15);
    send_frame(8'h00, N, 1'b1, 1'b0);
    drain();
    score(0, N, 20, 15, 1'b1, 8'h00, bad, fb, mk);
    n_checks++;
    if (q_pix.size() !== N) $display("FAIL center_count: got %0d want %0d", q_pix.size(), N);
    else n_pass++;
    n_checks++;
    if (bad !== 0 || fb !== 0) $display("FAIL center_pixels: got %0d/%0d wrong want 0", bad, fb);
    else n_pass++;
    n_checks++;
    if (mk !== 33) $display("FAIL center_marked_model: got %0d want 33", mk);
    else n_pass++;
    ref3 = q_pix;
  endtask

  task automatic test_mid_frame_update();
    int bad, fb, mk, nff;
    clear_q();
    send_frame(8'h00, 600, 1'b1, 1'b0);
    pulse_center(2, 0);
    send_frame(8'h00, 600, 1'b0, 1'b0);
    send_frame(8'h00, N, 1'b1, 1'b0);
    drain();
    score(0, N, 20, 15, 1'b1, 8'h00, bad, fb, mk);
    n_checks++;
    if (bad !== 0 || fb !== 0) $display("FAIL midframe_current: got %0d/%0d wrong want 0", bad, fb);
    else n_pass++;
    score(N, N, 2, 0, 1'b1, 8'h00, bad, fb, mk);
    n_checks++;
    if (bad !== 0 || fb !== 0) $display("FAIL midframe_next: got %0d/%0d wrong want 0", bad, fb);
    else n_pass++;
    nff = 0;
    for (int k = N; k < q_pix.size(); k++) if (q_pix[k] === 8'hFF) nff++;
    n_checks++;
    if (nff !== 19) $display("FAIL midframe_marked: got %0d want 19", nff);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int diff;
    clear_q();
    viol = 0;
    pulse_center(20, 15);
    send_frame(8'h00, N, 1'b1, 1'b1);
    drain();
    diff = 0;
    for (int k = 0; k < N; k++)
      if (k >= q_pix.size() || k >= ref3.size() || q_pix[k] !== ref3[k]) diff++;
    n_checks++;
    if (q_pix.size() !== N) $display("FAIL bp_count: got %0d want %0d", q_pix.size(), N);
    else n_pass++;
    n_checks++;
    if (diff !== 0) $display("FAIL bp_sequence: got %0d differing want 0", diff);
    else n_pass++;
    n_checks++;
    if (viol !== 0) $display("FAIL bp_in_ready: got %0d stalled-ready cycles want 0", viol);
    else n_pass++;
  endtask

  task automatic test_sof_error();
    int bad, fb, mk, e0, sofs;
    clear_q();
    bus.out_ready = 1'b1;
    e0 = err_cnt;
    send_frame(8'h10, 500, 1'b1, 1'b0);
    n_checks++;
    if (err_cnt - e0 !== 0) $display("FAIL sof_err_early: got %0d pulses want 0", err_cnt - e0);
    else n_pass++;
    send_frame(8'h10, N, 1'b1, 1'b0);
    drain();
    n_checks++;
    if (err_cnt - e0 !== 1) $display("FAIL sof_err_pulse: got %0d pulses want 1", err_cnt - e0);
    else n_pass++;
    n_checks++;
    if (q_pix.size() !== 500 + N) $display("FAIL sof_count: got %0d want %0d", q_pix.size(), 500 + N);
    else n_pass++;
    score(0, 500, 20, 15, 1'b1, 8'h10, bad, fb, mk);
    n_checks++;
    if (bad !== 0 || fb !== 0) $display("FAIL sof_prefix: got %0d/%0d wrong want 0", bad, fb);
    else n_pass++;
    score(500, N, 20, 15, 1'b1, 8'h10, bad, fb, mk);
    n_checks++;
    if (bad !== 0 || fb !== 0) $display("FAIL sof_restart: got %0d/%0d wrong want 0", bad, fb);
    else n_pass++;
    sofs = 0;
    for (int k = 0; k < q_sof.size(); k++) if (q_sof[k]) sofs++;
    n_checks++;
    if (sofs !== 2 || q_sof[500] !== 1'b1) $display("FAIL sof_flags: got %0d sof want 2 (at 0 and 500)", sofs);
    else n_pass++;
  endtask

  initial begin
    bus.in_valid     = 1'b0;
    bus.in_pixel     = 8'h00;
    bus.in_sof       = 1'b0;
    bus.center_valid = 1'b0;
    bus.xcenter      = 10'd0;
    bus.ycenter      = 10'd0;
    bus.out_ready    = 1'b1;
    test_reset();
    test_drop_before_sof();
    test_plain_frame();
    test_center();
    test_mid_frame_update();
    test_back_to_back();
    test_sof_error();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
